// File: rtl/blob_pkg.sv
// Shared definitions for the binary blob centroid block: FSM states,
// default resolution and the width-derivation helpers.
package blob_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

  localparam int DEF_H_RES = 320;
  localparam int DEF_V_RES = 240;

  // Width needed to count every pixel of a frame, including the all-set case.
  function automatic int cnt_width(input int h_res, input int v_res);
    return $clog2(h_res * v_res + 1);
  endfunction

  // Coordinate sums and the dividers share one width for both axes.
  function automatic int sum_width(input int xw, input int cntw);
    return xw + cntw;
  endfunction

endpackage

// File: rtl/blob_serial_div.sv
// Restoring serial divider: one quotient bit per cycle, W iterations.
// start is accepted only when idle; done pulses for one cycle after the
// last iteration, and quo then holds the low QW bits of the quotient.
module blob_serial_div #(
  parameter int W  = 26,
  parameter int QW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  dividend,
  input  logic [W-1:0]  divisor,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quo
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  quotient;
  logic [W-1:0]  rem;
  logic [W-1:0]  dvs;
  logic [CW-1:0] iter;
  logic [W:0]    trial;
  logic [W:0]    diff;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  assign trial = {rem, quotient[W-1]};
  assign diff  = trial - {1'b0, dvs};
  assign quo   = quotient[QW-1:0];

  // Load operands on start, then retire one quotient bit per cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient <= '0;
      rem      <= '0;
      dvs      <= '0;
      iter     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        quotient <= dividend;
        dvs      <= divisor;
        rem      <= '0;
        iter     <= CW'(W);
        busy     <= 1'b1;
      end else if (busy) begin
        if (trial >= {1'b0, dvs}) begin
          rem      <= diff[W-1:0];
          quotient <= {quotient[W-2:0], 1'b1};
        end else begin
          rem      <= trial[W-1:0];
          quotient <= {quotient[W-2:0], 1'b0};
        end
        iter <= iter - 1'b1;
        if (iter == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/binary_blob_centroid.sv
// Accumulates set-pixel count, coordinate sums and (optionally) bounding box
// over a raster frame of binary pixels, then computes the integer centroid
// with two serial dividers and presents one result per frame.
// Optional feature: define BLOB_BBOX_EN to build the bounding-box logic;
// without it X_MIN/X_MAX/Y_MIN/Y_MAX are tied to 0.
module binary_blob_centroid
  import blob_pkg::*;
#(
  parameter int H_RES = DEF_H_RES,
  parameter int V_RES = DEF_V_RES,
  parameter int XW    = 9,
  parameter int YW    = 8,
  parameter int CNTW  = cnt_width(H_RES, V_RES),
  parameter int SUMW  = sum_width(XW, CNTW)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            BIN_VALID,
  input  logic            BIN,
  input  logic            SOF,
  input  logic [CNTW-1:0] MIN_PIX,
  output logic            RESULT_VALID,
  output logic            FOUND,
  output logic [XW-1:0]   CX,
  output logic [YW-1:0]   CY,
  output logic [CNTW-1:0] PIX_CNT,
  output logic [XW-1:0]   X_MIN,
  output logic [XW-1:0]   X_MAX,
  output logic [YW-1:0]   Y_MIN,
  output logic [YW-1:0]   Y_MAX,
  output logic            OVERRUN
);

  state_t          state;
  logic [XW-1:0]   x, px;
  logic [YW-1:0]   y, py;
  logic [CNTW-1:0] acc_cnt, base_cnt, cnt_nx, snap_cnt;
  logic [SUMW-1:0] acc_sx, acc_sy, base_sx, base_sy, sx_nx, sy_nx, div_den;
  logic            hit, frame_end, start, latch_res;
  logic            x_busy, y_busy, x_done, y_done;
  logic [XW-1:0]   qx;
  logic [YW-1:0]   qy;

  // Effective coordinate and accumulator base: SOF resyncs to (0,0) with
  // empty accumulators before this cycle's pixel is applied.
  // NOTE: every combinational output is assigned a default before any
  // conditional override, so no latch can be inferred.
  always_comb begin
    px       = SOF ? '0 : x;
    py       = SOF ? '0 : y;
    base_cnt = SOF ? '0 : acc_cnt;
    base_sx  = SOF ? '0 : acc_sx;
    base_sy  = SOF ? '0 : acc_sy;
    hit      = BIN_VALID & BIN;
    cnt_nx   = base_cnt + CNTW'(hit);
    sx_nx    = base_sx + (hit ? SUMW'(px) : SUMW'(0));
    sy_nx    = base_sy + (hit ? SUMW'(py) : SUMW'(0));
  end

  assign frame_end = BIN_VALID && (px == XW'(H_RES - 1)) && (py == YW'(V_RES - 1));
  assign start     = frame_end && (state == IDLE) && !x_busy && !y_busy;
  assign latch_res = (state == DIV) && x_done && y_done;
  assign div_den   = SUMW'(cnt_nx);

  // Raster coordinate counters, advanced only by accepted pixels.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x <= '0;
      y <= '0;
    end else if (BIN_VALID) begin
      if (px == XW'(H_RES - 1)) begin
        x <= '0;
        y <= (py == YW'(V_RES - 1)) ? '0 : py + 1'b1;
      end else begin
        x <= px + 1'b1;
        y <= py;
      end
    end else if (SOF) begin
      x <= '0;
      y <= '0;
    end
  end

  // Frame accumulators; cleared at frame end so the next frame starts clean.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_cnt <= '0;
      acc_sx  <= '0;
      acc_sy  <= '0;
    end else if (frame_end) begin
      acc_cnt <= '0;
      acc_sx  <= '0;
      acc_sy  <= '0;
    end else begin
      acc_cnt <= cnt_nx;
      acc_sx  <= sx_nx;
      acc_sy  <= sy_nx;
    end
  end

  // Result FSM: snapshot at frame end, wait for both dividers, publish.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      snap_cnt     <= '0;
      RESULT_VALID <= 1'b0;
      FOUND        <= 1'b0;
      CX           <= '0;
      CY           <= '0;
      PIX_CNT      <= '0;
      OVERRUN      <= 1'b0;
    end else begin
      if (frame_end && (state != IDLE)) OVERRUN <= 1'b1;
      case (state)
        IDLE: begin
          RESULT_VALID <= 1'b0;
          if (start) begin
            snap_cnt <= cnt_nx;
            state    <= DIV;
          end
        end
        DIV: begin
          if (latch_res) begin
            state        <= DONE;
            RESULT_VALID <= 1'b1;
            PIX_CNT      <= snap_cnt;
            FOUND        <= (snap_cnt != '0) && (snap_cnt >= MIN_PIX);
            CX           <= (snap_cnt == '0) ? '0 : qx;
            CY           <= (snap_cnt == '0) ? '0 : qy;
          end
        end
        DONE: begin
          RESULT_VALID <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  blob_serial_div #(.W(SUMW), .QW(XW)) u_div_x (
    .clk      (CLK),
    .rst_n    (RST_N),
    .start    (start),
    .dividend (sx_nx),
    .divisor  (div_den),
    .busy     (x_busy),
    .done     (x_done),
    .quo      (qx)
  );

  blob_serial_div #(.W(SUMW), .QW(YW)) u_div_y (
    .clk      (CLK),
    .rst_n    (RST_N),
    .start    (start),
    .dividend (sy_nx),
    .divisor  (div_den),
    .busy     (y_busy),
    .done     (y_done),
    .quo      (qy)
  );

`ifdef BLOB_BBOX_EN
  logic [XW-1:0] acc_xmin, acc_xmax, xmin_nx, xmax_nx, snap_xmin, snap_xmax;
  logic [YW-1:0] acc_ymin, acc_ymax, ymin_nx, ymax_nx, snap_ymin, snap_ymax;

  // Bounding-box update; the first set pixel of a frame loads min and max.
  always_comb begin
    xmin_nx = SOF ? '0 : acc_xmin;
    xmax_nx = SOF ? '0 : acc_xmax;
    ymin_nx = SOF ? '0 : acc_ymin;
    ymax_nx = SOF ? '0 : acc_ymax;
    if (hit) begin
      if (base_cnt == '0) begin
        xmin_nx = px;
        xmax_nx = px;
        ymin_nx = py;
        ymax_nx = py;
      end else begin
        if (px < acc_xmin) xmin_nx = px;
        if (px > acc_xmax) xmax_nx = px;
        if (py < acc_ymin) ymin_nx = py;
        if (py > acc_ymax) ymax_nx = py;
      end
    end
  end

  // Bounding-box accumulators, snapshot and published outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      {acc_xmin, acc_xmax, acc_ymin, acc_ymax}     <= '0;
      {snap_xmin, snap_xmax, snap_ymin, snap_ymax} <= '0;
      {X_MIN, X_MAX, Y_MIN, Y_MAX}                 <= '0;
    end else begin
      if (frame_end) begin
        {acc_xmin, acc_xmax, acc_ymin, acc_ymax} <= '0;
      end else begin
        {acc_xmin, acc_xmax, acc_ymin, acc_ymax} <= {xmin_nx, xmax_nx, ymin_nx, ymax_nx};
      end
      if (start) begin
        {snap_xmin, snap_xmax, snap_ymin, snap_ymax} <= {xmin_nx, xmax_nx, ymin_nx, ymax_nx};
      end
      if (latch_res) begin
        if (snap_cnt == '0) begin
          {X_MIN, X_MAX, Y_MIN, Y_MAX} <= '0;
        end else begin
          {X_MIN, X_MAX, Y_MIN, Y_MAX} <= {snap_xmin, snap_xmax, snap_ymin, snap_ymax};
        end
      end
    end
  end
`else
  assign X_MIN = '0;
  assign X_MAX = '0;
  assign Y_MIN = '0;
  assign Y_MAX = '0;
`endif

endmodule

// File: tb/tb_binary_blob_centroid.sv
// Self-checking bench for binary_blob_centroid on an 8x4 frame. A bitmap
// model computes each frame's expected result; a per-cycle compare process
// checks the result strobe timing and the held outputs, and directed tests
// pin the model with hand-computed values.
module tb_binary_blob_centroid;

  localparam int H_RES = 8;
  localparam int V_RES = 4;
  localparam int XW    = 3;
  localparam int YW    = 2;
  localparam int CNTW  = 6;
  localparam int SUMW  = 9;
  localparam int LAT   = SUMW + 2;
`ifdef BLOB_BBOX_EN
  localparam bit BBOX_EN = 1'b1;
`else
  localparam bit BBOX_EN = 1'b0;
`endif

  typedef struct {
    int due;
    int cnt;
    int cx;
    int cy;
    int found;
    int xmin;
    int xmax;
    int ymin;
    int ymax;
  } res_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            bin_valid = 1'b0;
  logic            bin = 1'b0;
  logic            sof = 1'b0;
  logic [CNTW-1:0] min_pix = CNTW'(1);
  logic            result_valid, found, overrun;
  logic [XW-1:0]   cx, x_min, x_max;
  logic [YW-1:0]   cy, y_min, y_max;
  logic [CNTW-1:0] pix_cnt;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  res_t q[$];
  res_t held = '{default: 0};
  bit   img[V_RES][H_RES];

  binary_blob_centroid #(
    .H_RES(H_RES), .V_RES(V_RES), .XW(XW), .YW(YW), .CNTW(CNTW), .SUMW(SUMW)
  ) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .BIN_VALID    (bin_valid),
    .BIN          (bin),
    .SOF          (sof),
    .MIN_PIX      (min_pix),
    .RESULT_VALID (result_valid),
    .FOUND        (found),
    .CX           (cx),
    .CY           (cy),
    .PIX_CNT      (pix_cnt),
    .X_MIN        (x_min),
    .X_MAX        (x_max),
    .Y_MIN        (y_min),
    .Y_MAX        (y_max),
    .OVERRUN      (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame result straight from the bitmap: count, sums, floor division, bbox.
  function automatic res_t model(input int mp);
    res_t r;
    int   sx, sy;
    r  = '{default: 0};
    sx = 0;
    sy = 0;
    r.xmin = H_RES; r.xmax = -1; r.ymin = V_RES; r.ymax = -1;
    for (int yy = 0; yy < V_RES; yy++)
      for (int xx = 0; xx < H_RES; xx++)
        if (img[yy][xx]) begin
          r.cnt++;
          sx += xx;
          sy += yy;
          if (xx < r.xmin) r.xmin = xx;
          if (xx > r.xmax) r.xmax = xx;
          if (yy < r.ymin) r.ymin = yy;
          if (yy > r.ymax) r.ymax = yy;
        end
    if (r.cnt != 0) begin
      r.cx = sx / r.cnt;
      r.cy = sy / r.cnt;
    end
    r.found = (r.cnt != 0 && r.cnt >= mp) ? 1 : 0;
    if (r.cnt == 0 || !BBOX_EN) begin
      r.xmin = 0; r.xmax = 0; r.ymin = 0; r.ymax = 0;
    end
    return r;
  endfunction

  // Per-cycle compare: strobe exactly on the due cycle, outputs hold between.
  always @(negedge clk) begin
    bit ev;
    ev = 1'b0;
    if (!rst_n) begin
      q.delete();
      held = '{default: 0};
    end else if (q.size() > 0 && q[0].due == cyc) begin
      ev   = 1'b1;
      held = q.pop_front();
    end
    check("result_valid", result_valid, ev);
    check("found", found, held.found);
    check("cx", cx, held.cx);
    check("cy", cy, held.cy);
    check("pix_cnt", pix_cnt, held.cnt);
    check("x_min", x_min, held.xmin);
    check("x_max", x_max, held.xmax);
    check("y_min", y_min, held.ymin);
    check("y_max", y_max, held.ymax);
    check("overrun", overrun, 0);
  end

  task automatic drive(input bit v, input bit b, input bit s);
    @(posedge clk);
    #1;
    bin_valid = v;
    bin       = b;
    sof       = s;
  endtask

  task automatic clear_img();
    for (int yy = 0; yy < V_RES; yy++)
      for (int xx = 0; xx < H_RES; xx++)
        img[yy][xx] = 1'b0;
  endtask

  // Optional junk pixels (all set), then one full frame from the bitmap,
  // with idle gaps carrying BIN=1 and optionally SOF on the first pixel.
  task automatic send_frame(input int junk, input bit use_sof, output int c0);
    res_t r;
    c0 = 0;
    for (int j = 0; j < junk; j++) drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < H_RES * V_RES; i++) begin
      if (i % 7 == 3) drive(1'b0, 1'b1, 1'b0);
      drive(1'b1, img[i / H_RES][i % H_RES], use_sof && i == 0);
      if (i == H_RES * V_RES - 1) begin
        c0    = cyc;
        r     = model(int'(min_pix));
        r.due = c0 + LAT;
        q.push_back(r);
      end
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_result(input string name, input int c0);
    int lat;
    lat = -1;
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge clk);
      if (result_valid) begin
        lat = cyc - c0;
        break;
      end
    end
    check({name, "_latency"}, lat, LAT);
  endtask

  task automatic set_block();
    clear_img();
    img[1][4] = 1'b1; img[1][5] = 1'b1;
    img[2][4] = 1'b1; img[2][5] = 1'b1;
  endtask

  initial begin
    int   c0, pulses;
    res_t m;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_pix_cnt", pix_cnt, 0);
    check("reset_result_valid", result_valid, 0);

    // Single pixel at (3,2).
    clear_img();
    img[2][3] = 1'b1;
    m = model(1);
    check("model_t1_cx", m.cx, 3);
    check("model_t1_cy", m.cy, 2);
    send_frame(0, 1'b0, c0);
    wait_result("t1", c0);
    check("t1_cx", cx, 3);
    check("t1_cy", cy, 2);
    check("t1_pix_cnt", pix_cnt, 1);
    check("t1_found", found, 1);
    check("t1_x_min", x_min, BBOX_EN ? 3 : 0);
    check("t1_y_max", y_max, BBOX_EN ? 2 : 0);

    // 2x2 block: sum_x=18, sum_y=6.
    set_block();
    m = model(1);
    check("model_t2_cx", m.cx, 4);
    check("model_t2_cy", m.cy, 1);
    send_frame(0, 1'b0, c0);
    wait_result("t2", c0);
    check("t2_cx", cx, 4);
    check("t2_cy", cy, 1);
    check("t2_pix_cnt", pix_cnt, 4);
    check("t2_x_max", x_max, BBOX_EN ? 5 : 0);
    check("t2_y_min", y_min, BBOX_EN ? 1 : 0);

    // Empty frame.
    clear_img();
    send_frame(0, 1'b0, c0);
    wait_result("t3", c0);
    check("t3_found", found, 0);
    check("t3_cx", cx, 0);
    check("t3_pix_cnt", pix_cnt, 0);

    // Block below the area threshold.
    min_pix = CNTW'(5);
    set_block();
    send_frame(0, 1'b0, c0);
    wait_result("t4", c0);
    check("t4_found", found, 0);
    check("t4_cx", cx, 4);
    check("t4_pix_cnt", pix_cnt, 4);
    min_pix = CNTW'(1);

    // Junk pixels, then SOF resync and a frame holding only (7,3).
    clear_img();
    img[3][7] = 1'b1;
    send_frame(10, 1'b1, c0);
    wait_result("t5", c0);
    check("t5_cx", cx, 7);
    check("t5_cy", cy, 3);
    check("t5_pix_cnt", pix_cnt, 1);

    // Every pixel set: sum_x=112, sum_y=48 over 32 pixels.
    for (int yy = 0; yy < V_RES; yy++)
      for (int xx = 0; xx < H_RES; xx++)
        img[yy][xx] = 1'b1;
    m = model(1);
    check("model_t7_cx", m.cx, 3);
    check("model_t7_cy", m.cy, 1);
    send_frame(0, 1'b0, c0);
    wait_result("t7", c0);
    check("t7_pix_cnt", pix_cnt, 32);
    check("t7_cx", cx, 3);
    check("t7_cy", cy, 1);

    // Reset in the middle of a division: no pulse, outputs cleared.
    set_block();
    send_frame(0, 1'b0, c0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    check("t6_no_pulse", pulses, 0);
    check("t6_cx_cleared", cx, 0);
    check("t6_pix_cnt_cleared", pix_cnt, 0);

    clear_img();
    img[2][3] = 1'b1;
    send_frame(0, 1'b0, c0);
    wait_result("t6", c0);
    check("t6_cx", cx, 3);
    check("t6_cy", cy, 2);
    check("t6_pix_cnt", pix_cnt, 1);
    check("t6_overrun", overrun, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
